instr_sequencer: RTL

Multi-cycle fetch/decode/execute sequencer for the SPARC V8 datapath. It drives the register-load enables for MAR, MDR, IR, PC and nPC, plus the RAM handshake. It qualifies the instruction decoder's register-file and PSR writes, so each instruction commits exactly once. It sits between the instruction register and the decoder/datapath, and is the only block that advances PC/nPC.

---
 rtl/sparc_ctrl_pkg.sv | 21 ++
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/mfc_watchdog.sv | 18 +
 rtl/instr_sequencer.sv | 98 +++++++++
 4 files changed

// File: rtl/sparc_ctrl_pkg.sv
// sparc_ctrl_pkg: shared state encodings and opcode constants for the SPARC V8 control sequencer.
package sparc_ctrl_pkg;
  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_BRANCH     = 4'd4,
    ST_EXECUTE    = 4'd5,
    ST_MEM_ADDR   = 4'd6,
    ST_MEM_WAIT   = 4'd7,
    ST_LOAD_WB    = 4'd8,
    ST_FAULT      = 4'd9
  } state_t;
  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_MEM = 2'b11;
  localparam logic [5:0] RAM_OP_LDW = 6'b000000;
  localparam int STORE_BIT = 2;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction/RAM handshake and register-load enables between sequencer and datapath.
interface instr_sequencer_if;
  logic [31:0] IR_Out;
  logic MFC;
  logic cond_true;
  logic IR_Enable;
  logic MAR_Enable;
  logic MDR_Enable;
  logic PC_enable;
  logic NPC_enable;
  logic RAM_enable;
  logic [5:0] RAM_OpCode;
  logic MAR_Mux_select;
  logic MDR_Mux_select;
  logic NPC_Mux_select;
  logic cu_enable;
  logic [3:0] state_dbg;
  logic mem_fault;
  modport master (
    input IR_Out, MFC, cond_true,
    output IR_Enable, MAR_Enable, MDR_Enable, PC_enable, NPC_enable, RAM_enable, RAM_OpCode,
           MAR_Mux_select, MDR_Mux_select, NPC_Mux_select, cu_enable, state_dbg, mem_fault
  );
  modport slave (
    output IR_Out, MFC, cond_true,
    input IR_Enable, MAR_Enable, MDR_Enable, PC_enable, NPC_enable, RAM_enable, RAM_OpCode,
          MAR_Mux_select, MDR_Mux_select, NPC_Mux_select, cu_enable, state_dbg, mem_fault
  );
endinterface

// File: rtl/mfc_watchdog.sv
// mfc_watchdog: counts MFC-low wait cycles and flags a timeout on the last allowed cycle.
module mfc_watchdog #(
  parameter int MFC_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mfc,
  output logic timeout
);
  localparam int W = $clog2(MFC_TIMEOUT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!waiting) cnt <= '0;
    else if (!mfc) cnt <= cnt + 1'b1;
  assign timeout = waiting && !mfc && cnt == W'(MFC_TIMEOUT - 1);
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute control FSM; MFC_TIMEOUT_EN adds an MFC watchdog and FAULT state.
module instr_sequencer
  import sparc_ctrl_pkg::*;
`ifdef MFC_TIMEOUT_EN
#(
  parameter int MFC_TIMEOUT = 16
)
`endif
(
  input logic clk,
  input logic rst_n,
  instr_sequencer_if.master bus
);
  state_t state, nxt;
  logic [1:0] op;
  logic [5:0] op3;
  logic is_store;
  logic timeout;
  assign op = bus.IR_Out[31:30];
  assign op3 = bus.IR_Out[24:19];
  assign is_store = op3[STORE_BIT];
  assign bus.state_dbg = state;
`ifdef MFC_TIMEOUT_EN
  mfc_watchdog #(.MFC_TIMEOUT(MFC_TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .waiting(state == ST_FETCH_WAIT || state == ST_MEM_WAIT),
    .mfc(bus.MFC),
    .timeout(timeout)
  );
  assign bus.mem_fault = state == ST_FAULT;
`else
  assign timeout = 1'b0;
  assign bus.mem_fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_RESET;
    else state <= nxt;
  always_comb begin
    nxt = state;
    bus.IR_Enable = 1'b0;
    bus.MAR_Enable = 1'b0;
    bus.MDR_Enable = 1'b0;
    bus.PC_enable = 1'b0;
    bus.NPC_enable = 1'b0;
    bus.RAM_enable = 1'b0;
    bus.RAM_OpCode = RAM_OP_LDW;
    bus.MAR_Mux_select = 1'b0;
    bus.MDR_Mux_select = 1'b0;
    bus.NPC_Mux_select = 1'b0;
    bus.cu_enable = 1'b0;
    case (state)
      ST_RESET: nxt = ST_FETCH;
      ST_FETCH: begin
        bus.MAR_Enable = 1'b1;
        nxt = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        bus.RAM_enable = 1'b1;
        bus.IR_Enable = bus.MFC;
        nxt = bus.MFC ? ST_DECODE : timeout ? ST_FAULT : ST_FETCH_WAIT;
      end
      ST_DECODE: begin
        bus.PC_enable = 1'b1;
        bus.NPC_enable = 1'b1;
        nxt = op == OP_BRANCH ? ST_BRANCH : op == OP_ALU ? ST_EXECUTE : op == OP_MEM ? ST_MEM_ADDR : ST_FETCH;
      end
      ST_BRANCH: begin
        bus.NPC_enable = bus.cond_true;
        bus.NPC_Mux_select = bus.cond_true;
        nxt = ST_FETCH;
      end
      ST_EXECUTE: begin
        bus.cu_enable = 1'b1;
        nxt = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        bus.MAR_Enable = 1'b1;
        bus.MAR_Mux_select = 1'b1;
        bus.MDR_Enable = is_store;
        nxt = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        bus.RAM_enable = 1'b1;
        bus.RAM_OpCode = op3;
        bus.MDR_Enable = bus.MFC && !is_store;
        bus.MDR_Mux_select = bus.MFC && !is_store;
        nxt = bus.MFC ? (is_store ? ST_FETCH : ST_LOAD_WB) : timeout ? ST_FAULT : ST_MEM_WAIT;
      end
      ST_LOAD_WB: begin
        bus.cu_enable = 1'b1;
        nxt = ST_FETCH;
      end
      ST_FAULT: nxt = ST_FAULT;
      default: nxt = ST_RESET;
    endcase
  end
endmodule
